debug_sysbus_arb: RTL

- 2:1 arbiter sharing one system-bus master port between the hart LSU path (src 0) and the debug module sysbus master (src 1).
- Both requesters and the bus use the codebase's vld/rdy req/ack convention.
- Responses return in order and are routed back through an in-order source-ID FIFO.
- Sits in the dm_clk domain between debug_module, the hart LSU and the system interconnect.

---
 rtl/debug_pack.sv | 21 ++
 rtl/debug_arb_ord_fifo.sv | 51 +++++
 rtl/debug_sysbus_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/debug_pack.sv
// Shared types and constants for the debug-module system-bus path.
package debug_pack;

  localparam int SYSBUS_PLD_W = 69;

  localparam logic ARB_SRC_CORE = 1'b0;
  localparam logic ARB_SRC_DBG  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        opcode;
  } sysbus_req_pld_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/debug_arb_ord_fifo.sv
// In-order source-ID FIFO: one bit per outstanding bus transaction, head = oldest.
`default_nettype none
module debug_arb_ord_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   push_id,
  input  logic                   pop,
  output logic                   head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/debug_sysbus_arb.sv
// 2:1 arbiter (hart LSU = src 0, debug sysbus = src 1) onto one system-bus master port.
// Optional macro DEBUG_SYSBUS_ARB_DBG_PRIO_EN gives the debug source strict priority in IDLE.
`default_nettype none
module debug_sysbus_arb
  import debug_pack::*;
#(
  parameter int OST_DEPTH = 4,
  parameter int PLD_W     = SYSBUS_PLD_W
) (
  input  logic                        dm_clk,
  input  logic                        dm_rst,
  input  logic                        core_req_vld,
  output logic                        core_req_rdy,
  input  logic [PLD_W-1:0]            core_req_pld,
  output logic                        core_ack_vld,
  input  logic                        core_ack_rdy,
  output logic [31:0]                 core_ack_data,
  input  logic                        dbg_req_vld,
  output logic                        dbg_req_rdy,
  input  logic [PLD_W-1:0]            dbg_req_pld,
  output logic                        dbg_ack_vld,
  input  logic                        dbg_ack_rdy,
  output logic [31:0]                 dbg_ack_data,
  output logic                        bus_req_vld,
  input  logic                        bus_req_rdy,
  output logic [PLD_W-1:0]            bus_req_pld,
  input  logic                        bus_ack_vld,
  output logic                        bus_ack_rdy,
  input  logic [31:0]                 bus_ack_data,
  output logic [$clog2(OST_DEPTH):0]  ost_cnt,
  output logic                        err_orphan_ack
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       lock_src;
  logic       lock_src_nxt;
  logic       last_src;
  logic       idle_src;
  logic       sel_src;
  logic       sel_vld;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic       push;
  logic       pop;

`ifdef DEBUG_SYSBUS_ARB_DBG_PRIO_EN
  always_comb begin
    idle_src = dbg_req_vld ? ARB_SRC_DBG : ARB_SRC_CORE;
  end
`else
  always_comb begin
    idle_src = ARB_SRC_CORE;
    if (core_req_vld && dbg_req_vld) begin
      idle_src = ~last_src;
    end else if (dbg_req_vld) begin
      idle_src = ARB_SRC_DBG;
    end
  end
`endif

  always_comb begin
    state_nxt    = state;
    lock_src_nxt = lock_src;
    sel_src      = idle_src;
    sel_vld      = 1'b0;
    case (state)
      ARB_IDLE: begin
        sel_src = idle_src;
        sel_vld = !fifo_full && (core_req_vld || dbg_req_vld);
        if (sel_vld && !bus_req_rdy) begin
          state_nxt    = ARB_LOCKED;
          lock_src_nxt = idle_src;
        end
      end
      ARB_LOCKED: begin
        // Selection frozen so the bus sees a stable request until it accepts it.
        sel_src = lock_src;
        sel_vld = !fifo_full && ((lock_src == ARB_SRC_DBG) ? dbg_req_vld : core_req_vld);
        if (sel_vld && bus_req_rdy) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // last_src resets to the debug source so that the first tie after reset goes to the core.
  always_ff @(posedge dm_clk) begin
    if (dm_rst) begin
      state    <= ARB_IDLE;
      lock_src <= ARB_SRC_CORE;
      last_src <= ARB_SRC_DBG;
    end else begin
      state    <= state_nxt;
      lock_src <= lock_src_nxt;
      if (push) begin
        last_src <= sel_src;
      end
    end
  end

  assign bus_req_vld  = sel_vld;
  assign bus_req_pld  = !sel_vld ? '0 : ((sel_src == ARB_SRC_DBG) ? dbg_req_pld : core_req_pld);
  assign push         = sel_vld && bus_req_rdy;
  assign core_req_rdy = push && (sel_src == ARB_SRC_CORE);
  assign dbg_req_rdy  = push && (sel_src == ARB_SRC_DBG);

  // With nothing outstanding, acks are drained and flagged rather than routed.
  assign bus_ack_rdy   = fifo_empty ? bus_ack_vld
                                    : ((fifo_head == ARB_SRC_DBG) ? dbg_ack_rdy : core_ack_rdy);
  assign core_ack_vld  = bus_ack_vld && !fifo_empty && (fifo_head == ARB_SRC_CORE);
  assign dbg_ack_vld   = bus_ack_vld && !fifo_empty && (fifo_head == ARB_SRC_DBG);
  assign core_ack_data = bus_ack_data;
  assign dbg_ack_data  = bus_ack_data;
  assign pop           = bus_ack_vld && bus_ack_rdy && !fifo_empty;

  always_ff @(posedge dm_clk) begin
    if (dm_rst) begin
      err_orphan_ack <= 1'b0;
    end else if (bus_ack_vld && fifo_empty) begin
      err_orphan_ack <= 1'b1;
    end
  end

  debug_arb_ord_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_ord_fifo (
    .clk     (dm_clk),
    .rst     (dm_rst),
    .push    (push),
    .push_id (sel_src),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (ost_cnt)
  );

endmodule
`default_nettype wire
